// File: rtl/first_layer_frame_ctrl.sv
// Frame sequencer for FIRST_LAYER: streams one DxDx3 frame from R/G/B memories, counts layer outputs.
// Latency: rd_en -> valid_in/pxl_in is 1 cycle (synchronous memory, 1-cycle read latency).
// Backpressure: hold=1 in FEED suppresses the read and freezes rd_addr; hold is ignored elsewhere.
module first_layer_frame_ctrl #(
  parameter int D          = 9,
  parameter int data_width = 32,
  parameter int K          = 3,
  parameter int S          = 2,
  parameter int TMO        = 1024,
  localparam int O         = (D - K) / S + 1,
  localparam int NPIX      = D * D,
  localparam int NOUT      = O * O,
  localparam int AW        = $clog2(NPIX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [data_width-1:0] rd_data_1,
  input  logic [data_width-1:0] rd_data_2,
  input  logic [data_width-1:0] rd_data_3,
  output logic                  valid_in,
  output logic [data_width-1:0] pxl_in_1,
  output logic [data_width-1:0] pxl_in_2,
  output logic [data_width-1:0] pxl_in_3,
  input  logic                  valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic [AW-1:0]         out_cnt
);

  localparam int IW = $clog2(TMO + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] NOUT_W    = AW'(NOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]         idle_cnt;
  logic                  idle_to;
  logic                  cnt_full;
  logic                  cnt_en;
  logic [data_width-1:0] pxl_q_1, pxl_q_2, pxl_q_3;

  // Layer output is expected full when the saturating count hits NOUT.
  assign cnt_full = (out_cnt == NOUT_W);
  // Only FEED and DRAIN listen to the layer; strays in IDLE/DONE are dropped.
  assign cnt_en   = valid_out && ((state == FEED) || (state == DRAIN));
  // This cycle would be the TMO-th consecutive DRAIN cycle without a layer output.
  assign idle_to  = !valid_out && (idle_cnt == IDLE_LAST);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and read strobe.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FEED;
      end
      FEED: begin
        rd_en = !hold;
        if (!hold && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last pixel is presented in the first DRAIN cycle; any exit
        // needs at least one more cycle, so it is never cut off.
        if (cnt_full || idle_to) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address: rewound on an accepted start, advances on every issued read, parks on the last pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_addr <= '0;
    end else if ((state == IDLE) && start) begin
      rd_addr <= '0;
    end else if (rd_en && (rd_addr != LAST_ADDR)) begin
      rd_addr <= rd_addr + AW'(1);
    end
  end

  // Output counter and sticky error: overrun beyond NOUT or DRAIN timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_cnt   <= '0;
      frame_err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      out_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_en) begin
        if (cnt_full) frame_err <= 1'b1;
        else          out_cnt   <= out_cnt + AW'(1);
      end
      if ((state == DRAIN) && !cnt_full && idle_to) frame_err <= 1'b1;
    end
  end

  // Idle counter: consecutive DRAIN cycles without a layer output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if ((state == DRAIN) && !valid_out) begin
      idle_cnt <= idle_cnt + IW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  // valid_in is the read strobe delayed one cycle, aligned with the memory data.
  always_ff @(posedge clk) begin
    if (!reset) valid_in <= 1'b0;
    else        valid_in <= rd_en;
  end

  // Pixel holding register: captures the delivered pixel so pxl_in keeps it while valid_in is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pxl_q_1 <= '0;
      pxl_q_2 <= '0;
      pxl_q_3 <= '0;
    end else if (valid_in) begin
      pxl_q_1 <= rd_data_1;
      pxl_q_2 <= rd_data_2;
      pxl_q_3 <= rd_data_3;
    end
  end

  // Memory data arrives registered one cycle after rd_en, exactly when valid_in is high.
  always_comb begin
    pxl_in_1 = pxl_q_1;
    pxl_in_2 = pxl_q_2;
    pxl_in_3 = pxl_q_3;
    if (valid_in) begin
      pxl_in_1 = rd_data_1;
      pxl_in_2 = rd_data_2;
      pxl_in_3 = rd_data_3;
    end
  end

endmodule

// File: tb/tb_first_layer_frame_ctrl.sv
// Directed bench for first_layer_frame_ctrl (D=9, K=3, S=2, TMO=1024).
// Frame timing: start driven in cycle 0, reads of addr a in cycle a+1, DRAIN from cycle 82.
// Layer outputs are injected by a per-frame schedule (first cycle, step, count).
module tb_first_layer_frame_ctrl;
  localparam int DW   = 32;
  localparam int NPIX = 81;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          valid_out = 1'b0;
  logic [DW-1:0] rd_data_1 = '0;
  logic [DW-1:0] rd_data_2 = '0;
  logic [DW-1:0] rd_data_3 = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          valid_in;
  logic [DW-1:0] pxl_in_1, pxl_in_2, pxl_in_3;
  logic          busy, done, frame_err;
  logic [AW-1:0] out_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  first_layer_frame_ctrl #(
    .D(9), .data_width(DW), .K(3), .S(2), .TMO(1024)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .rd_data_3(rd_data_3),
    .valid_in(valid_in), .pxl_in_1(pxl_in_1), .pxl_in_2(pxl_in_2), .pxl_in_3(pxl_in_3),
    .valid_out(valid_out), .busy(busy), .done(done), .frame_err(frame_err), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f1(input int a);
    return 32'h1000_0000 + 32'(a) * 32'd7;
  endfunction
  function automatic logic [31:0] f2(input int a);
    return 32'h2000_0005 ^ (32'(a) * 32'd13);
  endfunction
  function automatic logic [31:0] f3(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // R/G/B frame memories, one-cycle synchronous read.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_1 <= f1(int'(rd_addr));
      rd_data_2 <= f2(int'(rd_addr));
      rd_data_3 <= f3(int'(rd_addr));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string name, input int hold_mod,
                           input int vo_first, input int vo_step, input int vo_n,
                           input int spam1, input int spam2, input int rst_c,
                           input int exp_done_c, input int exp_cnt, input int exp_err);
    int   sent = 0, exp_addr = 0, exp_pix = 0, n_rd = 0, n_vin = 0, n_done = 0;
    int   done_c = -1, cnt_at_done = -1, addr_at_rst = -1;
    int   addr_bad = 0, hold_bad = 0, lag_bad = 0, pix_bad = 0;
    logic err_at_done = 1'bx, err_c1 = 1'bx, busy_after = 1'bx;
    logic prev_rd_en = 1'b0;
    bit   after_rst;

    @(posedge clk); #1;
    start = 1'b1; hold = 1'b0; valid_out = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      @(posedge clk); #1;
      start     = (c == spam1) || (c == spam2);
      hold      = (hold_mod != 0) && (c % hold_mod == 0);
      valid_out = 1'b0;
      if (c >= vo_first && ((c - vo_first) % vo_step == 0) && sent < vo_n) begin
        valid_out = 1'b1;
        sent++;
      end
      reset = !(c == rst_c);
      #1;
      after_rst = (rst_c != 0) && (c > rst_c);
      if (c == 1) err_c1 = frame_err;
      if (rst_c != 0 && c == rst_c) addr_at_rst = int'(rd_addr);
      if (rst_c != 0 && c == rst_c + 1) begin
        check({name, " rst rd_en"}, 32'(rd_en), 32'd0);
        check({name, " rst rd_addr"}, 32'(rd_addr), 32'd0);
        check({name, " rst valid_in"}, 32'(valid_in), 32'd0);
        check({name, " rst pxl_in_1"}, pxl_in_1, 32'd0);
        check({name, " rst busy"}, 32'(busy), 32'd0);
        check({name, " rst out_cnt"}, 32'(out_cnt), 32'd0);
      end
      if (hold && rd_en) hold_bad++;
      if (!(rst_c != 0 && c == rst_c + 1) && (valid_in !== prev_rd_en)) lag_bad++;
      if (rd_en) begin
        if (int'(rd_addr) != exp_addr) addr_bad++;
        exp_addr++;
        n_rd++;
      end
      if (valid_in) begin
        if (pxl_in_1 !== f1(exp_pix) || pxl_in_2 !== f2(exp_pix) || pxl_in_3 !== f3(exp_pix))
          pix_bad++;
        exp_pix++;
        n_vin++;
      end else if (exp_pix > 0 && !after_rst) begin
        if (pxl_in_1 !== f1(exp_pix - 1) || pxl_in_3 !== f3(exp_pix - 1)) pix_bad++;
      end
      prev_rd_en = rd_en;
      if (done) begin
        n_done++;
        if (done_c < 0) begin
          done_c      = c;
          cnt_at_done = int'(out_cnt);
          err_at_done = frame_err;
        end
      end
      if (done_c >= 0 && c == done_c + 3) begin
        busy_after = busy;
        break;
      end
      if (rst_c != 0 && c == rst_c + 20) begin
        busy_after = busy;
        break;
      end
    end
    start = 1'b0; hold = 1'b0; valid_out = 1'b0; reset = 1'b1;

    check({name, " frame_err cleared by start"}, 32'(err_c1), 32'd0);
    check({name, " hold blocks read"}, 32'(hold_bad), 32'd0);
    check({name, " busy at end"}, 32'(busy_after), 32'd0);
    if (rst_c != 0) begin
      check({name, " rd_addr at reset"}, 32'(addr_at_rst), 32'd40);
      check({name, " no done after reset"}, 32'(n_done), 32'd0);
      check({name, " out_cnt after reset"}, 32'(out_cnt), 32'd0);
    end else begin
      check({name, " addr sequence"}, 32'(addr_bad), 32'd0);
      check({name, " read count"}, 32'(n_rd), 32'(NPIX));
      check({name, " valid_in lag"}, 32'(lag_bad), 32'd0);
      check({name, " valid_in count"}, 32'(n_vin), 32'(NPIX));
      check({name, " pixel data"}, 32'(pix_bad), 32'd0);
      check({name, " done pulses"}, 32'(n_done), 32'd1);
      check({name, " done cycle"}, 32'(done_c), 32'(exp_done_c));
      check({name, " out_cnt at done"}, 32'(cnt_at_done), 32'(exp_cnt));
      check({name, " frame_err at done"}, 32'(err_at_done), 32'(exp_err));
      check({name, " frame_err sticky"}, 32'(frame_err), 32'(exp_err));
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset valid_in", 32'(valid_in), 32'd0);
    check("reset pxl_in_1", pxl_in_1, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset out_cnt", 32'(out_cnt), 32'd0);
    reset = 1'b1;

    // name, hold_mod, vo_first, vo_step, vo_n, spam1, spam2, rst_c, done_c, out_cnt, err
    run_frame("t1",  0, 30, 4, 16,  0,  0,  0,   92, 16, 0);
    run_frame("t2",  3, 30, 4, 16,  0,  0,  0,  123, 16, 0);
    run_frame("t3",  0, 30, 4, 15,  0,  0,  0, 1111, 15, 1);
    run_frame("t3b", 0, 30, 4, 16,  0,  0,  0,   92, 16, 0);
    run_frame("t4",  0, 10, 2, 17,  0,  0,  0,   83, 16, 1);
    run_frame("t5",  0, 30, 4, 16,  0,  0, 41,    0,  0, 0);
    run_frame("t5b", 0, 30, 4, 16,  0,  0,  0,   92, 16, 0);
    run_frame("t6",  0, 30, 4, 16, 10, 85,  0,   92, 16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
